lcd_cmd_issuer: RTL and testbench

//  Upstream command stage for the LCD image controller. Buffers 3-bit host commands in a FIFO.

---
 rtl/lcd_cmd_issuer_if.sv | 27 ++
 rtl/lcd_cmd_issuer.sv | 143 ++++++++++++++
 tb/tb_lcd_cmd_issuer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_issuer_if.sv
// Host-side command handshake, controller command port and status for lcd_cmd_issuer.
// master = host/controller side, slave = the issuer.
interface lcd_cmd_issuer_if #(
    parameter int AW = 3
);
    logic [2:0]  host_cmd;
    logic        host_valid;
    logic        host_ready;
    logic        lcd_busy;
    logic        lcd_done;
    logic [2:0]  cmd;
    logic        cmd_valid;
    logic [AW:0] fifo_count;
    logic [7:0]  issued_cnt;
    logic        seq_done;
    logic        err;

    modport master (
        output host_cmd, host_valid, lcd_busy, lcd_done,
        input  host_ready, cmd, cmd_valid, fifo_count, issued_cnt, seq_done, err
    );

    modport slave (
        input  host_cmd, host_valid, lcd_busy, lcd_done,
        output host_ready, cmd, cmd_valid, fifo_count, issued_cnt, seq_done, err
    );
endinterface

// File: rtl/lcd_cmd_issuer.sv
// Buffers host commands and issues them one at a time to the LCD controller, retiring on WRITE.
// Optional busy/done watchdog enabled by defining CMD_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | wait for a queued command and controller not busy, then issue it
// GUARD  | one cycle after issue, busy ignored while the controller catches up
// WAIT   | controller busy with the issued command
// DRAIN  | WRITE accepted, waiting for the controller's done
// FINISH | stream retired, no further issue until reset
module lcd_cmd_issuer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
`ifdef CMD_TIMEOUT_EN
   ,parameter int TIMEOUT = 255
`endif
) (
    input  logic              clk,
    input  logic              reset,
    lcd_cmd_issuer_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, GUARD, WAIT, DRAIN, FINISH} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t      state_q;
    logic [2:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [2:0]  cmd_q;
    logic        cmd_valid_q;
    logic [7:0]  issued_cnt_q;
    logic        seq_done_q;

    logic [AW:0] count_w;
    logic        full_w;
    logic        empty_w;
    logic        pop_w;
    logic        push_w;
    logic        host_ready_w;

    assign count_w = wr_ptr_q - rd_ptr_q;
    assign full_w  = (count_w == DEPTH_C);
    assign empty_w = (count_w == '0);
    assign pop_w   = (state_q == IDLE) && !empty_w && !bus.lcd_busy;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign host_ready_w = (!full_w || pop_w) && (state_q != FINISH);
    assign push_w       = bus.host_valid && host_ready_w;

    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.host_cmd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

`ifdef CMD_TIMEOUT_EN
    localparam logic [7:0] WDOG_LOAD = 8'(TIMEOUT - 1);
    logic [7:0] wdog_q;
    logic       err_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            issued_cnt_q <= '0;
            seq_done_q   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            wdog_q       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            cmd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop_w) begin
                        cmd_q        <= mem_q[rd_ptr_q[AW-1:0]];
                        cmd_valid_q  <= 1'b1;
                        issued_cnt_q <= issued_cnt_q + 1'b1;
                        state_q      <= GUARD;
                    end
                end
                GUARD: begin
                    state_q <= WAIT;
`ifdef CMD_TIMEOUT_EN
                    wdog_q  <= WDOG_LOAD;
`endif
                end
                WAIT: begin
                    if (!bus.lcd_busy) begin
                        state_q <= (cmd_q == 3'd0) ? DRAIN : IDLE;
`ifdef CMD_TIMEOUT_EN
                        wdog_q  <= WDOG_LOAD;
                    end else if (wdog_q == '0) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        wdog_q  <= wdog_q - 1'b1;
`endif
                    end
                end
                DRAIN: begin
                    if (bus.lcd_done) begin
                        state_q    <= FINISH;
                        seq_done_q <= 1'b1;
`ifdef CMD_TIMEOUT_EN
                    end else if (wdog_q == '0) begin
                        err_q      <= 1'b1;
                        state_q    <= FINISH;
                        seq_done_q <= 1'b1;
                    end else begin
                        wdog_q     <= wdog_q - 1'b1;
`endif
                    end
                end
                FINISH: state_q <= FINISH;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.host_ready = host_ready_w;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.fifo_count = count_w;
    assign bus.issued_cnt = issued_cnt_q;
    assign bus.seq_done   = seq_done_q;
`ifdef CMD_TIMEOUT_EN
    assign bus.err        = err_q;
`else
    assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Scoreboard bench for lcd_cmd_issuer: stimulus queues expected commands, a monitor checks each strobe.
module tb_lcd_cmd_issuer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lcd_cmd_issuer_if #(.AW(3)) bus();
    lcd_cmd_issuer #(.DEPTH(8), .AW(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic model_en = 1'b0, model_busy = 1'b0, model_done = 1'b0;
    logic man_busy = 1'b0, man_done = 1'b0;
    assign bus.lcd_busy = model_en ? model_busy : man_busy;
    assign bus.lcd_done = model_done | man_done;

    int checks = 0;
    int failures = 0;
    logic [2:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // monitor: every strobe pops the scoreboard
    logic       mon_prev = 1'b0;
    logic [7:0] mon_n = 8'd0;
    logic [2:0] mon_exp;
    initial forever begin
        @(posedge clk); #1;
        if (reset) begin
            mon_n = 8'd0;
            mon_prev = 1'b0;
        end else begin
            if (bus.cmd_valid) begin
                chk("strobe_one_cycle", 32'(mon_prev), 0);
                mon_n = mon_n + 8'd1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cmd: actual=%0d required=none", bus.cmd);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("cmd_order", 32'(bus.cmd), 32'(mon_exp));
                end
                chk("issued_cnt_track", 32'(bus.issued_cnt), 32'(mon_n));
            end
            mon_prev = bus.cmd_valid;
        end
    end

    // controller model: busy for 2 cycles starting 1 cycle after the strobe, done after WRITE
    logic [2:0] model_c;
    initial forever begin
        @(posedge clk); #1;
        if (model_en && !reset && bus.cmd_valid) begin
            model_c = bus.cmd;
            @(negedge clk);
            @(negedge clk); model_busy = 1'b1;
            @(negedge clk);
            @(negedge clk); model_busy = 1'b0;
            if (model_c == 3'd0) begin
                @(negedge clk); model_done = 1'b1;
                @(negedge clk); model_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] c, input bit expect_issue);
        @(negedge clk);
        bus.host_valid = 1'b1;
        bus.host_cmd = c;
        if (expect_issue) exp_q.push_back(c);
    endtask

    task automatic host_idle();
        @(negedge clk);
        bus.host_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.host_valid = 1'b0;
        man_busy = 1'b0;
        man_done = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_seq_done(input int max);
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #1;
            if (bus.seq_done) break;
        end
        chk("seq_done", 32'(bus.seq_done), 1);
    endtask

    task automatic wait_strobe(input int max);
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #1;
            if (bus.cmd_valid) break;
        end
        chk("strobe_seen", 32'(bus.cmd_valid), 1);
    endtask

    task automatic wait_drained(input int max);
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
    endtask

    logic [2:0] cmds9 [9];

    initial begin
        bus.host_valid = 1'b0;
        bus.host_cmd = 3'd0;
        cmds9 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
        do_reset();

        // reset state
        @(posedge clk); #1;
        chk("rst_host_ready", 32'(bus.host_ready), 1);
        chk("rst_fifo_count", 32'(bus.fifo_count), 0);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
        chk("rst_issued_cnt", 32'(bus.issued_cnt), 0);
        chk("rst_seq_done", 32'(bus.seq_done), 0);
        chk("rst_err", 32'(bus.err), 0);

        // 1: commands 1,2,0 through the controller model
        model_en = 1'b1;
        @(negedge clk); bus.host_valid = 1'b1; bus.host_cmd = 3'd1; exp_q.push_back(3'd1);
        @(posedge clk); #1;
        chk("latency_early", 32'(bus.cmd_valid), 0);
        chk("count_after_push", 32'(bus.fifo_count), 1);
        @(negedge clk); bus.host_cmd = 3'd2; exp_q.push_back(3'd2);
        @(posedge clk); #1;
        chk("latency_2cyc", 32'(bus.cmd_valid), 1);
        chk("count_push_pop", 32'(bus.fifo_count), 1);
        @(negedge clk); bus.host_cmd = 3'd0; exp_q.push_back(3'd0);
        host_idle();
        wait_seq_done(100);
        chk("t1_issued_cnt", 32'(bus.issued_cnt), 3);
        chk("t1_host_ready_finish", 32'(bus.host_ready), 0);
        chk("t1_fifo_empty", 32'(bus.fifo_count), 0);
        chk("t1_cmd_holds", 32'(bus.cmd), 0);
        wait_drained(5);
        cycles(4);

        // 4: entries behind WRITE are never issued
        do_reset();
        push(3'd0, 1'b1);
        push(3'd3, 1'b0);
        host_idle();
        wait_seq_done(100);
        push(3'd5, 1'b0);
        push(3'd6, 1'b0);
        host_idle();
        cycles(3);
        chk("t4_fifo_count", 32'(bus.fifo_count), 1);
        chk("t4_host_ready", 32'(bus.host_ready), 0);
        chk("t4_issued_cnt", 32'(bus.issued_cnt), 1);
        wait_drained(5);
        model_en = 1'b0;

        // 2/3: fill while busy, then push and pop together on a full FIFO
        do_reset();
        man_busy = 1'b1;
        for (int i = 0; i < 8; i++) push(cmds9[i], 1'b1);
        @(posedge clk); #1;
        chk("t2_full_count", 32'(bus.fifo_count), 8);
        chk("t2_full_not_ready", 32'(bus.host_ready), 0);
        @(negedge clk); bus.host_cmd = cmds9[8]; exp_q.push_back(cmds9[8]);
        cycles(3);
        chk("t2_no_push_when_full", 32'(bus.fifo_count), 8);
        @(negedge clk); man_busy = 1'b0;
        #1;
        chk("t3_ready_on_pop", 32'(bus.host_ready), 1);
        @(posedge clk); #1;
        chk("t3_push_pop_full", 32'(bus.fifo_count), 8);
        chk("t3_strobe", 32'(bus.cmd_valid), 1);
        @(negedge clk); bus.host_valid = 1'b0; man_busy = 1'b1;
        cycles(2);
        chk("t3_hold_count", 32'(bus.fifo_count), 8);
        @(negedge clk); model_en = 1'b1;
        wait_drained(200);
        cycles(6);
        chk("t2_drained_count", 32'(bus.fifo_count), 0);
        chk("t2_issued_cnt", 32'(bus.issued_cnt), 9);
        chk("t2_seq_done", 32'(bus.seq_done), 0);

        // 5: reset during WAIT with 4 entries queued
        @(negedge clk); model_en = 1'b0; man_busy = 1'b0;
        push(3'd5, 1'b1);
        host_idle();
        wait_strobe(10);
        @(negedge clk); man_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(3'(i + 1), 1'b0);
        host_idle();
        man_done = 1'b1;
        @(negedge clk); man_done = 1'b0;
        cycles(1);
        chk("t5_queued", 32'(bus.fifo_count), 4);
        chk("t5_done_ignored", 32'(bus.seq_done), 0);
        @(negedge clk); reset = 1'b1;
        #1;
        chk("t5_rst_count", 32'(bus.fifo_count), 0);
        chk("t5_rst_cmd_valid", 32'(bus.cmd_valid), 0);
        chk("t5_rst_issued", 32'(bus.issued_cnt), 0);
        do_reset();

        // 6: busy held after issue
        push(3'd4, 1'b1);
        host_idle();
        wait_strobe(10);
        @(negedge clk); man_busy = 1'b1;
        repeat (255) @(posedge clk);
        #1;
        chk("t6_err_before", 32'(bus.err), 0);
        @(posedge clk); #1;
`ifdef CMD_TIMEOUT_EN
        chk("t6_err_after", 32'(bus.err), 1);
`else
        chk("t6_err_after", 32'(bus.err), 0);
`endif
        push(3'd6, 1'b1);
        host_idle();
        @(negedge clk); man_busy = 1'b0;
        wait_drained(20);
        cycles(2);
        chk("t6_issued_cnt", 32'(bus.issued_cnt), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
